// File: rtl/toggle_line_pkg.sv
// ---------------------------------------------------------------------------
// toggle_line_pkg
// Shared types and constants for the toggle line decoder.
//   line_state_t : tracked line level (Blue = 0, Red = 1)
//   SYM_BLUE/RED : legal level symbols on the link
//   ctrl_state_t : control FSM states (PARITY used only when
//                  TOGGLE_DEC_PARITY_EN is defined)
// ---------------------------------------------------------------------------
package toggle_line_pkg;

    typedef enum logic {Blue = 1'h0, Red = 1'h1} line_state_t;

    localparam logic [1:0] SYM_BLUE = 2'h1;
    localparam logic [1:0] SYM_RED  = 2'h2;

    typedef enum logic [1:0] {
        HUNT   = 2'h0,
        SHIFT  = 2'h1,
        PARITY = 2'h2
    } ctrl_state_t;

    // Only the two level symbols are legal; 2'h0 and 2'h3 are line errors.
    function automatic logic sym_is_legal(input logic [1:0] s);
        return (s == SYM_BLUE) || (s == SYM_RED);
    endfunction

    function automatic line_state_t sym_level(input logic [1:0] s);
        return (s == SYM_RED) ? Red : Blue;
    endfunction

endpackage

// File: rtl/toggle_line_out_reg.sv
// ---------------------------------------------------------------------------
// toggle_line_out_reg
// One-entry valid/ready holding register for decoded words.
//   clk, rst      : clock, asynchronous active-high reset
//   load          : a completed word is offered this cycle
//   load_data     : the offered word
//   ready         : consumer accepts when valid & ready
//   ovf_clr       : clears the sticky overflow flag
//   data, valid   : held word towards the consumer
//   overflow      : sticky, a completed word was dropped
//   drop          : combinational, the offered word is being dropped now
// ---------------------------------------------------------------------------
module toggle_line_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ready,
    input  logic                  ovf_clr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  overflow,
    output logic                  drop
);

    logic accept;

    assign accept = valid && ready;
    // A word completing while the held one is not leaving is lost; the
    // held word has priority so the consumer never sees data change early.
    assign drop   = load && valid && !ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (load && !drop) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (accept) begin
                valid <= 1'b0;
            end
            // A new drop wins over a simultaneous clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/toggle_line_decoder.sv
// ---------------------------------------------------------------------------
// toggle_line_decoder
// Receive side of the Blue/Red toggle line code. Tracks the line level,
// decodes each symbol into a bit (1 = level changed), frames a start bit
// followed by DATA_WIDTH data bits LSB first, and hands whole words to a
// valid/ready consumer.
//   clk, rst     : clock, asynchronous active-high reset
//   sym_valid    : sym is sampled this cycle
//   sym          : 2'h1 Blue, 2'h2 Red, others illegal
//   word_data    : assembled word, bit 0 = first data bit
//   word_valid   : word_data held for the consumer
//   word_ready   : consumer accept
//   line_level   : tracked level, 0 = Blue, 1 = Red
//   sym_err      : one-cycle pulse after an illegal symbol
//   overflow     : sticky, a completed word was dropped
//   ovf_clr      : clears overflow
//   par_err      : parity error pulse
// Build option: define TOGGLE_DEC_PARITY_EN to add an even-parity symbol
// after the data bits; otherwise par_err is tied to 0.
// ---------------------------------------------------------------------------
module toggle_line_decoder
    import toggle_line_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sym_valid,
    input  logic [1:0]            sym,
    output logic [DATA_WIDTH-1:0] word_data,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  line_level,
    output logic                  sym_err,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  par_err
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    line_state_t           line_level_reg;
    ctrl_state_t           state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;
    logic                  sym_err_reg;
    logic                  legal;
    logic                  dbit;
    logic                  shift_en;
    logic                  complete;
    logic [DATA_WIDTH-1:0] complete_data;
    logic                  drop;

    assign legal = sym_is_legal(sym);
    assign dbit  = (sym_level(sym) != line_level_reg);

    // Each data bit lands at the position selected by the bit counter.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
            assign shreg_next[gi] = (shift_en && (cnt_reg == CW'(gi))) ? dbit : shreg_reg[gi];
        end
    endgenerate

`ifdef TOGGLE_DEC_PARITY_EN
    logic par_bad;
    logic par_err_reg;
    // Data is complete in the register by the time the parity symbol arrives.
    assign complete_data = shreg_reg;
    assign par_err       = par_err_reg;
`else
    // Last data bit is merged on the fly so the word loads on its own edge.
    assign complete_data = shreg_next;
    assign par_err       = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_en   = 1'b0;
        complete   = 1'b0;
`ifdef TOGGLE_DEC_PARITY_EN
        par_bad    = 1'b0;
`endif
        if (sym_valid) begin
            if (!legal) begin
                // Abort any frame in progress; resynchronise on next start bit.
                state_next = HUNT;
                cnt_next   = '0;
            end else begin
                case (state_reg)
                    HUNT: begin
                        if (dbit) begin
                            state_next = SHIFT;
                            cnt_next   = '0;
                        end
                    end
                    SHIFT: begin
                        shift_en = 1'b1;
                        if (cnt_reg == LAST_BIT) begin
                            cnt_next = '0;
`ifdef TOGGLE_DEC_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = HUNT;
                            complete   = 1'b1;
`endif
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
`ifdef TOGGLE_DEC_PARITY_EN
                    PARITY: begin
                        state_next = HUNT;
                        // Even parity over data plus parity bit.
                        if ((^shreg_reg) == dbit) begin
                            complete = 1'b1;
                        end else begin
                            par_bad = 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_next = HUNT;
                        cnt_next   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_level_reg <= Red;
            state_reg      <= HUNT;
            cnt_reg        <= '0;
            shreg_reg      <= '0;
            sym_err_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shreg_reg   <= shreg_next;
            sym_err_reg <= sym_valid && !legal;
            if (sym_valid && legal) begin
                line_level_reg <= sym_level(sym);
            end
        end
    end

`ifdef TOGGLE_DEC_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_reg <= 1'b0;
        end else begin
            par_err_reg <= par_bad;
        end
    end
`endif

    assign line_level = line_level_reg;
    assign sym_err    = sym_err_reg;

    toggle_line_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .load_data (complete_data),
        .ready     (word_ready),
        .ovf_clr   (ovf_clr),
        .data      (word_data),
        .valid     (word_valid),
        .overflow  (overflow),
        .drop      (drop)
    );

    // drop is already reflected in overflow; kept as a visible debug net.
    logic drop_unused;
    assign drop_unused = drop;

endmodule

// File: tb/tb_toggle_line_decoder.sv
// ---------------------------------------------------------------------------
// tb_toggle_line_decoder
// Self-checking bench for toggle_line_decoder (DATA_WIDTH = 8). A behavioural
// encoder (a single level bit toggled per 1 bit) produces symbols; expected
// words are kept as a plain queue and compared with handshaken output words.
// ---------------------------------------------------------------------------
module tb_toggle_line_decoder;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sym_valid;
    logic [1:0]    sym;
    logic [DW-1:0] word_data;
    logic          word_valid;
    logic          word_ready;
    logic          line_level;
    logic          sym_err;
    logic          overflow;
    logic          ovf_clr;
    logic          par_err;

    int n_checks = 0;
    int n_pass   = 0;

    bit            tx_level;
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    toggle_line_decoder #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .line_level (line_level),
        .sym_err    (sym_err),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .par_err    (par_err)
    );

    // One clock: handshakes are recorded just before the edge that takes them.
    task automatic tick();
        @(negedge clk);
        if (word_valid && word_ready) begin
            rx_q.push_back(word_data);
            $display("rx word 0x%h", word_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [1:0] s);
        sym_valid = 1'b1;
        sym       = s;
        if (s == 2'h1 || s == 2'h2) tx_level = (s == 2'h2);
        tick();
        sym_valid = 1'b0;
        sym       = 2'h0;
    endtask

    task automatic send_bit(input bit b);
        send_sym((tx_level ^ b) ? 2'h2 : 2'h1);
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input bit flip_par);
        send_bit(1'b1);
        for (int i = 0; i < DW; i++) send_bit(w[i]);
`ifdef TOGGLE_DEC_PARITY_EN
        send_bit((^w) ^ flip_par);
`else
        if (flip_par) $display("note: parity flip ignored in this build");
`endif
    endtask

    task automatic consume();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (line_level !== 1'b1) $display("FAIL reset_level got %b want 1", line_level); else n_pass++;
        n_checks++;
        if (word_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", word_valid); else n_pass++;
        n_checks++;
        if (word_data !== '0) $display("FAIL reset_data got %h want 00", word_data); else n_pass++;
        n_checks++;
        if ({sym_err, overflow, par_err} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {sym_err, overflow, par_err});
        else n_pass++;
        n_checks++;
        rst      = 1'b0;
        tx_level = 1'b1;
    endtask

    task automatic test_basic();
        logic [1:0] seq [8];
        seq = '{2'h2, 2'h2, 2'h1, 2'h1, 2'h1, 2'h2, 2'h2, 2'h1};
        word_ready = 1'b0;
        send_sym(2'h2);
        send_sym(2'h1);
        for (int i = 0; i < 7; i++) send_sym(seq[i]);
        if (word_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", word_valid); else n_pass++;
        n_checks++;
        send_sym(seq[7]);
`ifdef TOGGLE_DEC_PARITY_EN
        send_bit(1'b0);
`endif
        if (word_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", word_valid); else n_pass++;
        n_checks++;
        if (word_data !== 8'hA5) $display("FAIL basic_data got %h want a5", word_data); else n_pass++;
        n_checks++;
        if (line_level !== tx_level) $display("FAIL basic_level got %b want %b", line_level, tx_level); else n_pass++;
        n_checks++;
        consume();
        if (word_valid !== 1'b0) $display("FAIL basic_consumed got %b want 0", word_valid); else n_pass++;
        n_checks++;
    endtask

    task automatic test_overflow();
        word_ready = 1'b0;
        send_frame(8'hA5, 1'b0);
        send_frame(8'hFF, 1'b0);
        if (word_data !== 8'hA5) $display("FAIL ovf_held got %h want a5", word_data); else n_pass++;
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else n_pass++;
        n_checks++;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        if (overflow !== 1'b0) $display("FAIL ovf_clr got %b want 0", overflow); else n_pass++;
        n_checks++;
        // Clear held high through a dropping completion: set must win.
        ovf_clr = 1'b1;
        send_frame(8'h22, 1'b0);
        ovf_clr = 1'b0;
        if (overflow !== 1'b1) $display("FAIL ovf_set_wins got %b want 1", overflow); else n_pass++;
        n_checks++;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        consume();
        rx_q.delete();
    endtask

    task automatic test_illegal();
        bit            lvl;
        logic [1:0]    bad;
        logic [DW-1:0] w;
        rx_q.delete();
        word_ready = 1'b1;
        send_bit(1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        lvl = tx_level;
        bad = ($urandom_range(0, 1) == 0) ? 2'h0 : 2'h3;
        send_sym(bad);
        if (sym_err !== 1'b1) $display("FAIL illegal_err got %b want 1", sym_err); else n_pass++;
        n_checks++;
        if (line_level !== lvl) $display("FAIL illegal_level got %b want %b", line_level, lvl); else n_pass++;
        n_checks++;
        tick();
        if (sym_err !== 1'b0) $display("FAIL illegal_pulse got %b want 0", sym_err); else n_pass++;
        n_checks++;
        tick();
        if (rx_q.size() != 0 || word_valid !== 1'b0)
            $display("FAIL illegal_noword got %0d words valid %b want 0", rx_q.size(), word_valid);
        else n_pass++;
        n_checks++;
        w = DW'($urandom);
        send_frame(w, 1'b0);
        tick();
        tick();
        if (rx_q.size() != 1) $display("FAIL illegal_recover_cnt got %0d want 1", rx_q.size());
        else if (rx_q[0] !== w) $display("FAIL illegal_recover got %h want %h", rx_q[0], w);
        else n_pass++;
        n_checks++;
        word_ready = 1'b0;
    endtask

    task automatic check_stream(input string name);
        if (rx_q.size() != exp_q.size())
            $display("FAIL %s_count got %0d want %0d", name, rx_q.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) $display("FAIL %s_word%0d got %h want %h", name, i, rx_q[i], exp_q[i]);
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w;
        rx_q.delete();
        exp_q.delete();
        word_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            w = DW'($urandom);
            exp_q.push_back(w);
            send_frame(w, 1'b0);
        end
        repeat (3) tick();
        check_stream("b2b");
        if (overflow !== 1'b0) $display("FAIL b2b_overflow got %b want 0", overflow); else n_pass++;
        n_checks++;
        word_ready = 1'b0;
    endtask

    task automatic test_random_gaps();
        logic [DW-1:0] w;
        rx_q.delete();
        exp_q.delete();
        word_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 1) == 0) send_bit(1'b0);
                else tick();
            end
            w = DW'($urandom);
            exp_q.push_back(w);
            send_frame(w, 1'b0);
        end
        repeat (3) tick();
        check_stream("rand");
        if (line_level !== tx_level) $display("FAIL rand_level got %b want %b", line_level, tx_level); else n_pass++;
        n_checks++;
        word_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w;
        word_ready = 1'b0;
        send_frame(8'h3C, 1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        #2 rst = 1'b1;
        #1;
        if (line_level !== 1'b1) $display("FAIL rstmid_level got %b want 1", line_level); else n_pass++;
        n_checks++;
        if (word_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", word_valid); else n_pass++;
        n_checks++;
        @(posedge clk);
        #1 rst = 1'b0;
        tx_level = 1'b1;
        send_bit(1'b0);
        w = DW'($urandom);
        send_frame(w, 1'b0);
        if (word_valid !== 1'b1 || word_data !== w)
            $display("FAIL rstmid_frame got %b/%h want 1/%h", word_valid, word_data, w);
        else n_pass++;
        n_checks++;
        consume();
    endtask

`ifdef TOGGLE_DEC_PARITY_EN
    task automatic test_parity();
        word_ready = 1'b0;
        send_frame(8'hA5, 1'b0);
        if (word_valid !== 1'b1 || word_data !== 8'hA5)
            $display("FAIL par_good got %b/%h want 1/a5", word_valid, word_data);
        else n_pass++;
        n_checks++;
        consume();
        send_frame(8'hA5, 1'b1);
        if (par_err !== 1'b1) $display("FAIL par_err got %b want 1", par_err); else n_pass++;
        n_checks++;
        if (word_valid !== 1'b0) $display("FAIL par_drop got %b want 0", word_valid); else n_pass++;
        n_checks++;
        tick();
        if (par_err !== 1'b0 || overflow !== 1'b0)
            $display("FAIL par_pulse got %b/%b want 0/0", par_err, overflow);
        else n_pass++;
        n_checks++;
    endtask
`endif

    initial begin
        rst        = 1'b1;
        sym_valid  = 1'b0;
        sym        = 2'h0;
        word_ready = 1'b0;
        ovf_clr    = 1'b0;
        tx_level   = 1'b1;
        test_reset();
        test_basic();
        test_overflow();
        test_illegal();
        test_back_to_back();
        test_random_gaps();
        test_reset_mid();
`ifdef TOGGLE_DEC_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
